// File: rtl/serial_input_pkg.sv
// Shared types and helpers for the serial_input UART receiver.
package serial_input_pkg;

  localparam int DATA_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  function automatic int clocks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

  function automatic int half_bit(input int cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/serial_sync.sv
// Two-flop synchronizer with a selectable reset value.
module serial_sync #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_input.sv
// 8N1 UART receiver feeding a 32-bit stb/ack stream
// through a one-entry holding register.
module serial_input
  import serial_input_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] output_rs232_rx,
  output logic              output_rs232_rx_stb,
  input  logic              output_rs232_rx_ack,
  output logic              framing_error,
  output logic              overrun
);

  localparam int CPB  = clocks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int HALF = half_bit(CPB);
  localparam int CW   = $clog2(CPB);

  localparam logic [CW-1:0] LAST      = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  if (CPB < 4) begin : g_bad_rate
    $error("serial_input: CLOCKS_PER_BIT must be at least 4");
  end

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2:0]         idx;
  logic [BYTE_W-1:0]  shift;
  logic [BYTE_W-1:0]  held;
  logic               rx_s;
  logic               rx_q;
  logic               at_bit;
  logic               byte_done;

  serial_sync #(.RESET_VALUE(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign at_bit    = (cnt == LAST);
  assign byte_done = (state == STOP) && at_bit && rx_s;

  assign output_rs232_rx = {{(DATA_W-BYTE_W){1'b0}}, held};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      cnt                 <= '0;
      idx                 <= '0;
      shift               <= '0;
      held                <= '0;
      rx_q                <= 1'b1;
      output_rs232_rx_stb <= 1'b0;
      framing_error       <= 1'b0;
      overrun             <= 1'b0;
    end else begin
      rx_q          <= rx_s;
      framing_error <= 1'b0;
      overrun       <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_q && !rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (at_bit) begin
            cnt   <= '0;
            shift <= {rx_s, shift[BYTE_W-1:1]};
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (at_bit) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              framing_error <= 1'b1;
              state         <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A byte may load in the same cycle the held one is taken.
      if (byte_done) begin
        if (!output_rs232_rx_stb || output_rs232_rx_ack) begin
          held                <= shift;
          output_rs232_rx_stb <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (output_rs232_rx_stb && output_rs232_rx_ack) begin
        output_rs232_rx_stb <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_input.sv
// Directed bench for serial_input with a transaction-level reference model.
module tb_serial_input;

  localparam int CPB  = 16;
  localparam int HALF = 8;
  // Start-drive edge to stop-sample edge: 2 sync + 1 edge-detect,
  // half a bit to mid-start, then 8 data bits and the stop bit.
  localparam int STOP_EDGE = 3 + HALF + 9 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        ack = 1'b0;
  logic [31:0] dout;
  logic        stb;
  logic        fe;
  logic        ov;

  int n_checks = 0;
  int n_fail   = 0;

  serial_input #(
    .CLOCK_FREQUENCY(16),
    .BAUD_RATE      (1)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rx                  (rx),
    .output_rs232_rx     (dout),
    .output_rs232_rx_stb (stb),
    .output_rs232_rx_ack (ack),
    .framing_error       (fe),
    .overrun             (ov)
  );

  always #5 clk = ~clk;

  // Reference model state
  int         cyc = 0;
  bit         pend_valid = 0;
  int         pend_cyc = 0;
  logic [7:0] pend_byte = '0;
  bit         pend_ok = 0;
  logic       m_stb = 0;
  logic [7:0] m_data = '0;
  logic       m_fe = 0;
  logic       m_ov = 0;

  bit         checks_on = 0;
  logic [7:0] rcv[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         stb_cnt = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_stb      = 0;
      m_data     = '0;
      m_fe       = 0;
      m_ov       = 0;
      pend_valid = 0;
    end else begin
      bit done;
      cyc++;
      m_fe = 0;
      m_ov = 0;
      done = pend_valid && (cyc == pend_cyc);
      if (done) pend_valid = 0;
      if (done && !pend_ok) m_fe = 1;
      if (done && pend_ok) begin
        if (!m_stb || ack) begin
          m_data = pend_byte;
          m_stb  = 1;
        end else begin
          m_ov = 1;
        end
      end else if (m_stb && ack) begin
        m_stb = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (checks_on) begin
      check("stb", {31'b0, stb}, {31'b0, m_stb});
      if (m_stb) check("data", dout, {24'b0, m_data});
      check("framing_error", {31'b0, fe}, {31'b0, m_fe});
      check("overrun", {31'b0, ov}, {31'b0, m_ov});
      if (stb && ack) rcv.push_back(dout[7:0]);
      if (stb) stb_cnt++;
      if (fe) fe_cnt++;
      if (ov) ov_cnt++;
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clk);
    #1;
    rx         = 1'b0;
    pend_cyc   = cyc + STOP_EDGE;
    pend_byte  = b;
    pend_ok    = stop_bit;
    pend_valid = 1;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rx = stop_bit;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    rcv.delete();
    fe_cnt  = 0;
    ov_cnt  = 0;
    stb_cnt = 0;
  endtask

  task automatic expect_rcv(input string name, input int n,
                            input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2);
    logic [7:0] exp [3];
    exp[0] = b0;
    exp[1] = b1;
    exp[2] = b2;
    check({name, "_count"}, rcv.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < rcv.size()) check({name, "_byte"}, {24'b0, rcv[i]}, {24'b0, exp[i]});
      else check({name, "_missing"}, 32'hdead, {24'b0, exp[i]});
    end
  endtask

  initial begin
    #3 rst = 1'b0;
    idle(4);
    check("reset_stb", {31'b0, stb}, 32'd0);
    check("reset_data", dout, 32'd0);
    check("reset_fe", {31'b0, fe}, 32'd0);
    check("reset_ov", {31'b0, ov}, 32'd0);
    rst = 1'b1;
    checks_on = 1;
    idle(5);

    // 1: back-to-back bytes with ack held
    clear_stats();
    ack = 1'b1;
    send_frame(8'h55, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h00, 1'b1);
    idle(5);
    expect_rcv("t1", 3, 8'h55, 8'hFF, 8'h00);
    check("t1_stb_cycles", stb_cnt, 3);
    check("t1_fe", fe_cnt, 0);
    check("t1_ov", ov_cnt, 0);

    // 2: short glitch is a false start
    clear_stats();
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(30);
    check("t2_glitch_rcv", rcv.size(), 0);
    check("t2_glitch_fe", fe_cnt, 0);
    send_frame(8'hA5, 1'b1);
    idle(5);
    expect_rcv("t2", 1, 8'hA5, 8'h00, 8'h00);

    // 3: bad stop bit then held-low break
    clear_stats();
    send_frame(8'hA3, 1'b0);
    idle(40);
    rx = 1'b1;
    idle(20);
    check("t3_fe", fe_cnt, 1);
    check("t3_rcv_none", rcv.size(), 0);
    send_frame(8'h3C, 1'b1);
    idle(5);
    expect_rcv("t3", 1, 8'h3C, 8'h00, 8'h00);
    check("t3_fe_after", fe_cnt, 1);

    // 4: overrun while holding
    clear_stats();
    ack = 1'b0;
    send_frame(8'h11, 1'b1);
    idle(3);
    send_frame(8'h22, 1'b1);
    idle(3);
    check("t4_stb", {31'b0, stb}, 32'd1);
    check("t4_held", dout, 32'h11);
    check("t4_ov", ov_cnt, 1);
    ack = 1'b1;
    idle(1);
    ack = 1'b0;
    idle(5);
    check("t4_stb_drop", {31'b0, stb}, 32'd0);
    expect_rcv("t4", 1, 8'h11, 8'h00, 8'h00);

    // 5: take and reload in the same cycle
    clear_stats();
    send_frame(8'h11, 1'b1);
    idle(3);
    fork
      send_frame(8'h44, 1'b1);
      begin
        @(posedge clk);
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1 ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
      end
    join
    idle(3);
    check("t5_stb", {31'b0, stb}, 32'd1);
    check("t5_held", dout, 32'h44);
    check("t5_ov", ov_cnt, 0);
    ack = 1'b1;
    idle(1);
    ack = 1'b0;
    idle(3);
    expect_rcv("t5", 2, 8'h11, 8'h44, 8'h00);

    // 6: reset mid-frame with a byte held
    clear_stats();
    send_frame(8'h33, 1'b1);
    idle(3);
    check("t6_pre_stb", {31'b0, stb}, 32'd1);
    fork
      send_frame(8'h99, 1'b1);
      begin
        @(posedge clk);
        repeat (88) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("t6_rst_stb", {31'b0, stb}, 32'd0);
        check("t6_rst_data", dout, 32'd0);
      end
    join
    idle(3);
    rst = 1'b1;
    idle(5);
    ack = 1'b1;
    send_frame(8'h7E, 1'b1);
    idle(5);
    expect_rcv("t6", 1, 8'h7E, 8'h00, 8'h00);
    check("t6_fe", fe_cnt, 0);
    check("t6_ov", ov_cnt, 0);

    checks_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
